// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types for the core memory path. The package holds the machine word,
// the RAM handshake states and the arbiter FSM states.
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    // Handshake reported by the RAM for the request currently presented to it.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Ownership of the shared RAM port.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2,
        FAULT  = 2'd3
    } mem_arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single RAM port between the instruction cache and the data cache.
// One requester is granted at a time. Its address, store data and enables are
// routed to the RAM. Load data is broadcast to both caches. Each cache's wait
// signal stays high until its own access completes. A RAM ERROR response is
// retried by holding the grant. When more than MAX_RETRY consecutive errors
// occur in one transaction, the arbiter locks into FAULT until reset.
//
// Ports
//   CLK, RST                       clock, asynchronous active-high reset
//   icache_REN, icache_addr        icache fill request
//   dcache_REN, dcache_WEN,
//   dcache_addr, dcache_store      dcache read/write request
//   ram_state, ram_load            RAM handshake and read data
//   ram_REN, ram_WEN,
//   ram_addr, ram_store            RAM request from the current owner
//   icache_wait, dcache_wait       high while the cache's request is pending
//   icache_load, dcache_load       RAM read data
//   mem_error                      sticky fatal RAM error
//
// Configuration
//   MEM_ARBITER_RR_EN  defined: round-robin tie break in IDLE.
//                      undefined: dcache always wins a tie.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_RETRY = 3,
    parameter int LOG_RETRY = $clog2(MAX_RETRY + 1)
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      icache_REN,
    input  word_t     icache_addr,
    input  logic      dcache_REN,
    input  logic      dcache_WEN,
    input  word_t     dcache_addr,
    input  word_t     dcache_store,
    input  ramstate_t ram_state,
    input  word_t     ram_load,
    output logic      ram_REN,
    output logic      ram_WEN,
    output word_t     ram_addr,
    output word_t     ram_store,
    output logic      icache_wait,
    output logic      dcache_wait,
    output word_t     icache_load,
    output word_t     dcache_load,
    output logic      mem_error
);

    mem_arb_state_t       state, state_next;
    logic [LOG_RETRY-1:0] retry_cnt, retry_next;
    logic                 i_req, d_req, owner_req;
    logic                 i_done, d_done;
    logic                 pick_d;

    assign i_req     = icache_REN;
    assign d_req     = dcache_REN | dcache_WEN;
    assign owner_req = (state == IGRANT) ? i_req : d_req;
    assign i_done    = (state == IGRANT) && i_req && (ram_state == ACCESS);
    assign d_done    = (state == DGRANT) && d_req && (ram_state == ACCESS);

`ifdef MEM_ARBITER_RR_EN
    // last_d is high when dcache was the most recent owner. On a tie, the
    // other requester wins.
    logic last_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_d <= 1'b1;
        end else if (state == IDLE && state_next == DGRANT) begin
            last_d <= 1'b1;
        end else if (state == IDLE && state_next == IGRANT) begin
            last_d <= 1'b0;
        end
    end

    assign pick_d = ~last_d;
`else
    assign pick_d = 1'b1;
`endif

    always_comb begin
        state_next = state;
        retry_next = retry_cnt;
        unique case (state)
            IDLE: begin
                retry_next = '0;
                if (d_req && (!i_req || pick_d)) begin
                    state_next = DGRANT;
                end else if (i_req) begin
                    state_next = IGRANT;
                end
            end
            IGRANT, DGRANT: begin
                // A dropped request (abort) and a completion both return to
                // IDLE. The one-cycle bubble keeps a still-high request that
                // just completed from being re-granted.
                if (!owner_req || ram_state == ACCESS) begin
                    state_next = IDLE;
                    retry_next = '0;
                end else if (ram_state == ERROR) begin
                    if (retry_cnt == LOG_RETRY'(MAX_RETRY)) begin
                        state_next = FAULT;
                    end else begin
                        retry_next = retry_cnt + LOG_RETRY'(1);
                    end
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            retry_cnt <= '0;
        end else begin
            state     <= state_next;
            retry_cnt <= retry_next;
        end
    end

    // RAM side: the request of the owner only, so nothing reaches the RAM
    // while idle or faulted.
    always_comb begin
        ram_REN   = 1'b0;
        ram_WEN   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        unique case (state)
            IGRANT: begin
                ram_REN  = icache_REN;
                ram_addr = icache_addr;
            end
            DGRANT: begin
                ram_REN   = dcache_REN & ~dcache_WEN;
                ram_WEN   = dcache_WEN;
                ram_addr  = dcache_addr;
                ram_store = dcache_store;
            end
            default: begin
            end
        endcase
    end

    assign mem_error   = (state == FAULT);
    assign icache_wait = mem_error | (i_req & ~i_done);
    assign dcache_wait = mem_error | (d_req & ~d_done);
    assign icache_load = ram_load;
    assign dcache_load = ram_load;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Bench for mem_arbiter. It runs directed scenarios and then randomized
// traffic. All outputs are compared every cycle against a transaction-level
// model of port ownership kept in the bench.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int MAX_RETRY = 3;

    logic      CLK = 1'b0;
    logic      RST;
    logic      icache_REN, dcache_REN, dcache_WEN;
    word_t     icache_addr, dcache_addr, dcache_store, ram_load;
    ramstate_t ram_state;
    logic      ram_REN, ram_WEN, icache_wait, dcache_wait, mem_error;
    word_t     ram_addr, ram_store, icache_load, dcache_load;

    mem_arbiter #(.MAX_RETRY(MAX_RETRY)) dut (
        .CLK(CLK), .RST(RST),
        .icache_REN(icache_REN), .icache_addr(icache_addr),
        .dcache_REN(dcache_REN), .dcache_WEN(dcache_WEN),
        .dcache_addr(dcache_addr), .dcache_store(dcache_store),
        .ram_state(ram_state), .ram_load(ram_load),
        .ram_REN(ram_REN), .ram_WEN(ram_WEN),
        .ram_addr(ram_addr), .ram_store(ram_store),
        .icache_wait(icache_wait), .dcache_wait(dcache_wait),
        .icache_load(icache_load), .dcache_load(dcache_load),
        .mem_error(mem_error)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the port (0 nobody, 1 icache, 2 dcache,
    // 3 dead), how many errors the current transaction has seen, and who
    // was granted last (1 icache, 2 dcache).
    int m_owner, m_errs, m_last;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_errs  = 0;
        m_last  = 2;
    endtask

    // One clock edge of the ownership rules.
    task automatic model_step();
        bit ireq, dreq, mine;
        ireq = icache_REN;
        dreq = dcache_REN || dcache_WEN;
        if (RST) begin
            model_reset();
        end else if (m_owner == 0) begin
            m_errs = 0;
            if (ireq && dreq) begin
`ifdef MEM_ARBITER_RR_EN
                m_owner = (m_last == 2) ? 1 : 2;
`else
                m_owner = 2;
`endif
            end else if (dreq) begin
                m_owner = 2;
            end else if (ireq) begin
                m_owner = 1;
            end
            if (m_owner != 0) m_last = m_owner;
        end else if (m_owner != 3) begin
            mine = (m_owner == 1) ? ireq : dreq;
            if (!mine || ram_state == ACCESS) begin
                m_owner = 0;
                m_errs  = 0;
            end else if (ram_state == ERROR) begin
                if (m_errs == MAX_RETRY) m_owner = 3;
                else m_errs++;
            end
        end
    endtask

    task automatic check_outputs(input string ctx);
        logic  e_ren, e_wen, e_iw, e_dw, e_err;
        word_t e_addr, e_store;
        e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0; e_err = 0;
        if (m_owner == 1) begin
            e_ren  = icache_REN;
            e_addr = icache_addr;
        end else if (m_owner == 2) begin
            e_wen   = dcache_WEN;
            e_ren   = dcache_REN && !dcache_WEN;
            e_addr  = dcache_addr;
            e_store = dcache_store;
        end
        e_iw = icache_REN && !(m_owner == 1 && ram_state == ACCESS);
        e_dw = (dcache_REN || dcache_WEN) && !(m_owner == 2 && ram_state == ACCESS);
        if (m_owner == 3) begin
            e_iw = 1; e_dw = 1; e_err = 1;
        end
        check_val({ctx, ":ram_REN"},     32'(ram_REN),     32'(e_ren));
        check_val({ctx, ":ram_WEN"},     32'(ram_WEN),     32'(e_wen));
        check_val({ctx, ":ram_addr"},    ram_addr,         e_addr);
        check_val({ctx, ":ram_store"},   ram_store,        e_store);
        check_val({ctx, ":icache_wait"}, 32'(icache_wait), 32'(e_iw));
        check_val({ctx, ":dcache_wait"}, 32'(dcache_wait), 32'(e_dw));
        check_val({ctx, ":mem_error"},   32'(mem_error),   32'(e_err));
        check_val({ctx, ":icache_load"}, icache_load,      ram_load);
        check_val({ctx, ":dcache_load"}, dcache_load,      ram_load);
    endtask

    // Inputs change at the falling edge; outputs are checked 1 ns later.
    task automatic drive(input logic ir, input word_t ia, input logic dr, input logic dw,
                         input word_t da, input word_t ds, input ramstate_t rs,
                         input word_t rl, input string ctx);
        @(negedge CLK);
        icache_REN = ir; icache_addr = ia;
        dcache_REN = dr; dcache_WEN = dw; dcache_addr = da; dcache_store = ds;
        ram_state = rs; ram_load = rl;
        #1;
        check_outputs(ctx);
    endtask

    task automatic advance();
        @(posedge CLK);
        model_step();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        model_reset();
        #1;
        check_outputs("reset");
        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b0;
    endtask

    initial begin
        logic  ir, dr, dw, i_fin, d_fin;
        word_t ia, da, ds;
        ramstate_t rs;
        int r;

        RST = 1'b1;
        icache_REN = 0; icache_addr = '0; dcache_REN = 0; dcache_WEN = 0;
        dcache_addr = '0; dcache_store = '0; ram_state = FREE; ram_load = '0;
        model_reset();
        #2;
        check_val("reset:ram_REN", 32'(ram_REN), 32'd0);
        check_val("reset:mem_error", 32'(mem_error), 32'd0);
        // Wait outputs follow requests while reset is held.
        drive(1, 32'h40, 0, 0, 0, 0, FREE, 0, "reset_req");
        check_val("reset_req:icache_wait", 32'(icache_wait), 32'd1);
        check_val("reset_req:ram_addr", ram_addr, 32'd0);
        @(posedge CLK);
        #2 RST = 1'b0;

        // icache only: BUSY x2 then ACCESS.
        drive(1, 32'h40, 0, 0, 0, 0, FREE, 0, "ic_n");
        advance();
        drive(1, 32'h40, 0, 0, 0, 0, BUSY, 0, "ic_n1");
        check_val("ic_n1:ram_addr", ram_addr, 32'h40);
        check_val("ic_n1:ram_REN", 32'(ram_REN), 32'd1);
        advance();
        drive(1, 32'h40, 0, 0, 0, 0, BUSY, 0, "ic_n2");
        advance();
        drive(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'hDEADBEEF, "ic_acc");
        check_val("ic_acc:icache_wait", 32'(icache_wait), 32'd0);
        check_val("ic_acc:icache_load", icache_load, 32'hDEADBEEF);
        advance();
        drive(1, 32'h40, 0, 0, 0, 0, FREE, 0, "ic_bubble");
        check_val("ic_bubble:ram_REN", 32'(ram_REN), 32'd0);
        advance();
        drive(0, 32'h40, 0, 0, 0, 0, FREE, 0, "ic_drop");
        advance();
        drive(0, 0, 0, 0, 0, 0, FREE, 0, "idle");
        advance();

        // Contention: dcache write against icache read.
        drive(1, 32'h80, 0, 1, 32'h100, 32'h1234, FREE, 0, "ct_n");
        advance();
        drive(1, 32'h80, 0, 1, 32'h100, 32'h1234, ACCESS, 0, "ct_n1");
`ifndef MEM_ARBITER_RR_EN
        check_val("ct_n1:ram_WEN", 32'(ram_WEN), 32'd1);
        check_val("ct_n1:ram_addr", ram_addr, 32'h100);
        check_val("ct_n1:ram_store", ram_store, 32'h1234);
`endif
        advance();
        drive(1, 32'h80, 0, 0, 32'h100, 32'h1234, FREE, 0, "ct_bubble");
        advance();
        drive(1, 32'h80, 0, 0, 0, 0, ACCESS, 32'h77, "ct_i");
`ifndef MEM_ARBITER_RR_EN
        check_val("ct_i:ram_addr", ram_addr, 32'h80);
`endif
        advance();
        drive(0, 0, 0, 0, 0, 0, FREE, 0, "ct_end");
        advance();
        // A second tie.
        drive(1, 32'h84, 1, 0, 32'h104, 0, FREE, 0, "ct2_n");
        advance();
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'h84, 1, 0, 32'h104, 0, (k == 1 || k == 4) ? ACCESS : BUSY, k, "ct2");
            advance();
        end
        drive(0, 0, 0, 0, 0, 0, FREE, 0, "ct2_end");
        advance();

        // Retry: 2 then 3 errors complete; 4 errors fault.
        for (int n = 2; n <= 4; n++) begin
            drive(0, 0, 1, 0, 32'h200, 0, FREE, 0, "rt_n");
            advance();
            for (int e = 0; e < n; e++) begin
                drive(0, 0, 1, 0, 32'h200, 0, ERROR, 0, "rt_err");
                advance();
            end
            drive(0, 0, 1, 0, 32'h200, 0, ACCESS, 32'hCAFE, "rt_acc");
            if (n < 4) begin
                check_val("rt_acc:dcache_wait", 32'(dcache_wait), 32'd0);
                check_val("rt_acc:mem_error", 32'(mem_error), 32'd0);
            end else begin
                check_val("rt_fault:mem_error", 32'(mem_error), 32'd1);
                check_val("rt_fault:dcache_wait", 32'(dcache_wait), 32'd1);
            end
            advance();
            drive(0, 0, 0, 0, 0, 0, FREE, 0, "rt_drop");
            advance();
        end
        drive(1, 32'h44, 0, 0, 0, 0, ACCESS, 0, "fault_hold");
        check_val("fault_hold:mem_error", 32'(mem_error), 32'd1);
        check_val("fault_hold:icache_wait", 32'(icache_wait), 32'd1);
        advance();
        do_reset();
        check_val("post_fault:mem_error", 32'(mem_error), 32'd0);

        // Abort: icache drops its request at N+2.
        drive(1, 32'h48, 0, 0, 0, 0, FREE, 0, "ab_n");
        advance();
        drive(1, 32'h48, 0, 0, 0, 0, BUSY, 0, "ab_n1");
        advance();
        drive(0, 32'h48, 0, 0, 0, 0, BUSY, 0, "ab_n2");
        check_val("ab_n2:icache_wait", 32'(icache_wait), 32'd0);
        advance();
        drive(0, 0, 0, 0, 0, 0, ACCESS, 0, "ab_n3");
        check_val("ab_n3:ram_REN", 32'(ram_REN), 32'd0);
        advance();

        // Reset in the middle of a dcache write.
        drive(0, 0, 0, 1, 32'h300, 32'h55, FREE, 0, "rm_n");
        advance();
        drive(0, 0, 0, 1, 32'h300, 32'h55, BUSY, 0, "rm_n1");
        check_val("rm_n1:ram_WEN", 32'(ram_WEN), 32'd1);
        #1 RST = 1'b1;
        model_reset();
        #1;
        check_val("rm_async:ram_WEN", 32'(ram_WEN), 32'd0);
        check_outputs("rm_async");
        advance();
        #2 RST = 1'b0;
        drive(0, 0, 0, 1, 32'h300, 32'h55, BUSY, 0, "rm_rel");
        advance();
        drive(0, 0, 0, 1, 32'h300, 32'h55, ACCESS, 0, "rm_regrant");
        check_val("rm_regrant:ram_WEN", 32'(ram_WEN), 32'd1);
        advance();

        // Randomized traffic from protocol-following caches.
        ir = 0; dr = 0; dw = 0; i_fin = 0; d_fin = 0;
        ia = '0; da = '0; ds = '0;
        for (int c = 0; c < 3000; c++) begin
            if (m_owner == 3 && $urandom_range(0, 3) == 0) do_reset();
            if (ir && (i_fin || $urandom_range(0, 19) == 0)) ir = 0;
            else if (!ir && $urandom_range(0, 2) == 0) begin
                ir = 1; ia = $urandom;
            end
            if ((dr || dw) && (d_fin || $urandom_range(0, 29) == 0)) begin
                dr = 0; dw = 0;
            end else if (!(dr || dw) && $urandom_range(0, 2) == 0) begin
                r = $urandom_range(1, 3);
                dr = r[0]; dw = r[1]; da = $urandom; ds = $urandom;
            end
            r = $urandom_range(0, 9);
            rs = (r < 2) ? FREE : (r < 5) ? BUSY : (r < 9) ? ACCESS : ERROR;
            drive(ir, ia, dr, dw, da, ds, rs, $urandom, "rand");
            i_fin = icache_REN && !icache_wait;
            d_fin = (dcache_REN || dcache_WEN) && !dcache_wait;
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
